ntt_core_gf64_pmr_arb: RTL and testbench

- Shares one ntt_core_gf64_pmr partial-modular-reduction instance between N_REQ requesters (butterfly lanes, twiddle-multiply post-reduction, debug port) in the GF64 NTT core.
- Round-robin arbitration, one operation issued per cycle. Per-requester credit flow control, because the pmr output path has no backpressure.
- The requester ID travels in the pmr side channel. Results are routed back to the owning requester with a per-requester out_avail.

---
 rtl/ntt_core_gf64_pmr_arb.sv | 233 +++++++++++++++++++++++
 tb/tb_ntt_core_gf64_pmr_arb.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_core_gf64_pmr_arb.sv
// Round-robin, credit-controlled arbiter sharing one GF64 partial modular
// reduction unit (ntt_core_gf64_pmr) between N_REQ requesters. The
// requester ID rides in the pmr side channel so results can be routed back.

// Partial reduction for MOD_M = 2^64 - 2^32 + 1, using 2^64 == 2^32 - 1.
// Latency is IN_PIPE input stages plus one compute stage.
module ntt_core_gf64_pmr #(
    parameter int MOD_NTT_W = 64,
    parameter int OP_W      = MOD_NTT_W + 3,
    parameter int SIDE_W    = 10,
    parameter int IN_PIPE   = 1
) (
    input  logic                        clk,
    input  logic                        s_rst_n,
    input  logic                        in_avail,
    input  logic [OP_W-1:0]             a,
    input  logic [SIDE_W-1:0]           in_side,
    output logic                        out_avail,
    output logic signed [MOD_NTT_W+1:0] z,
    output logic [SIDE_W-1:0]           out_side
);
    localparam int Z_W  = MOD_NTT_W + 2;
    localparam int HI_W = OP_W - MOD_NTT_W;

    logic                    st_avail;
    logic [OP_W-1:0]         st_a;
    logic [SIDE_W-1:0]       st_side;
    logic [HI_W-1:0]         a_hi;
    logic signed [Z_W-1:0]   lo_ext;
    logic signed [Z_W-1:0]   hi_ext;
    logic signed [Z_W-1:0]   red;

    if (IN_PIPE == 0) begin : g_no_pipe
        assign st_avail = in_avail;
        assign st_a     = a;
        assign st_side  = in_side;
    end else begin : g_pipe
        logic [IN_PIPE-1:0]        sr_avail;
        logic [IN_PIPE*OP_W-1:0]   sr_a;
        logic [IN_PIPE*SIDE_W-1:0] sr_side;

        // Input pipeline valid bits, cleared by reset so nothing emerges afterwards
        always_ff @(posedge clk) begin
            if (!s_rst_n) begin
                sr_avail <= '0;
            end else begin
                sr_avail[0] <= in_avail;
                for (int s = 1; s < IN_PIPE; s++) sr_avail[s] <= sr_avail[s-1];
            end
        end

        // Input pipeline data, no reset needed
        always_ff @(posedge clk) begin
            sr_a[OP_W-1:0]      <= a;
            sr_side[SIDE_W-1:0] <= in_side;
            for (int s = 1; s < IN_PIPE; s++) begin
                sr_a[s*OP_W +: OP_W]       <= sr_a[(s-1)*OP_W +: OP_W];
                sr_side[s*SIDE_W +: SIDE_W] <= sr_side[(s-1)*SIDE_W +: SIDE_W];
            end
        end

        assign st_avail = sr_avail[IN_PIPE-1];
        assign st_a     = sr_a[(IN_PIPE-1)*OP_W +: OP_W];
        assign st_side  = sr_side[(IN_PIPE-1)*SIDE_W +: SIDE_W];
    end

    // Fold the signed high bits back in: z = lo + hi*2^32 - hi, fits in Z_W signed
    always_comb begin
        a_hi   = st_a[OP_W-1:MOD_NTT_W];
        lo_ext = {2'b00, st_a[MOD_NTT_W-1:0]};
        hi_ext = {{(Z_W-HI_W){a_hi[HI_W-1]}}, a_hi};
        red    = lo_ext + (hi_ext <<< (MOD_NTT_W/2)) - hi_ext;
    end

    // Output stage valid
    always_ff @(posedge clk) begin
        if (!s_rst_n) out_avail <= 1'b0;
        else          out_avail <= st_avail;
    end

    // Output stage data
    always_ff @(posedge clk) begin
        z        <= red;
        out_side <= st_side;
    end
endmodule

module ntt_core_gf64_pmr_arb #(
    parameter int N_REQ     = 4,
    parameter int MOD_NTT_W = 64,
    parameter int OP_W      = MOD_NTT_W + 3,
    parameter int USER_W    = 8,
    parameter int IN_PIPE   = 1,
    parameter int CREDIT_NB = 4
) (
    input  logic                        clk,
    input  logic                        s_rst_n,
    input  logic [N_REQ-1:0]            req_vld,
    output logic [N_REQ-1:0]            req_rdy,
    input  logic [N_REQ*OP_W-1:0]       req_a,
    input  logic [N_REQ*USER_W-1:0]     req_side,
    input  logic [N_REQ-1:0]            credit_rtn,
    output logic [N_REQ-1:0]            out_avail,
    output logic signed [MOD_NTT_W+1:0] out_z,
    output logic [USER_W-1:0]           out_side,
    output logic                        busy,
    output logic                        error_credit
);
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SIDE_W = ID_W + USER_W;
    localparam int CR_W   = $clog2(CREDIT_NB + 1);
    localparam int IF_W   = $clog2(N_REQ * CREDIT_NB + 1);

    logic [CR_W-1:0]   credit [N_REQ];
    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  grant;
    logic              grant_any;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W:0]     scan_idx;
    logic [ID_W-1:0]   rr_ptr;
    logic [IF_W-1:0]   inflight;

    logic              issue_vld;
    logic [OP_W-1:0]   issue_a;
    logic [SIDE_W-1:0] issue_side;

    logic                        pmr_avail;
    logic signed [MOD_NTT_W+1:0] pmr_z;
    logic [SIDE_W-1:0]           pmr_side;
    logic [ID_W-1:0]             out_id;

    // A requester may compete only with valid data and a free sink slot
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = s_rst_n & req_vld[i] & (credit[i] != '0);
        end
    end

    // Round-robin scan starting at rr_ptr, first eligible requester wins
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(N_REQ)) scan_idx = scan_idx - (ID_W+1)'(N_REQ);
            if (!grant_any && elig[scan_idx[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx[ID_W-1:0];
            end
        end
        grant = grant_any ? (N_REQ'(1) << grant_id) : '0;
    end

    assign req_rdy = grant;

    // Pointer moves just past the last winner, holds when idle
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    // Per-requester credits; an over-return is flagged and otherwise ignored
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            for (int i = 0; i < N_REQ; i++) credit[i] <= CR_W'(CREDIT_NB);
            error_credit <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                case ({grant[i], credit_rtn[i]})
                    2'b10:   credit[i] <= credit[i] - CR_W'(1);
                    2'b01: begin
                        if (credit[i] == CR_W'(CREDIT_NB)) error_credit <= 1'b1;
                        else                               credit[i] <= credit[i] + CR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Issue register valid
    always_ff @(posedge clk) begin
        if (!s_rst_n) issue_vld <= 1'b0;
        else          issue_vld <= grant_any;
    end

    // Issue register data: winning operand tagged with its requester ID
    always_ff @(posedge clk) begin
        if (grant_any) begin
            issue_a    <= req_a[grant_id*OP_W +: OP_W];
            issue_side <= {grant_id, req_side[grant_id*USER_W +: USER_W]};
        end
    end

    ntt_core_gf64_pmr #(
        .MOD_NTT_W (MOD_NTT_W),
        .OP_W      (OP_W),
        .SIDE_W    (SIDE_W),
        .IN_PIPE   (IN_PIPE)
    ) u_pmr (
        .clk       (clk),
        .s_rst_n   (s_rst_n),
        .in_avail  (issue_vld),
        .a         (issue_a),
        .in_side   (issue_side),
        .out_avail (pmr_avail),
        .z         (pmr_z),
        .out_side  (pmr_side)
    );

    // Operations between grant and result; bounded by total credits
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            inflight <= '0;
        end else begin
            case ({grant_any, pmr_avail})
                2'b10:   inflight <= inflight + IF_W'(1);
                2'b01:   inflight <= inflight - IF_W'(1);
                default: ;
            endcase
        end
    end

    assign out_id    = pmr_side[SIDE_W-1 -: ID_W];
    assign out_avail = (s_rst_n && pmr_avail) ? (N_REQ'(1) << out_id) : '0;
    assign out_z     = pmr_z;
    assign out_side  = pmr_side[USER_W-1:0];
    assign busy      = s_rst_n & ((inflight != '0) | issue_vld);
endmodule

// File: tb/tb_ntt_core_gf64_pmr_arb.sv
// Directed and random checks for the shared pmr arbiter: routing, latency,
// round-robin order, credit flow control, reset flush and modular results.
module tb_ntt_core_gf64_pmr_arb;
    localparam int N    = 4;
    localparam int OPW  = 67;
    localparam int UW   = 8;
    localparam int ZW   = 66;

    typedef struct {
        int          id;
        logic [66:0] a;
        logic [7:0]  side;
        logic [63:0] exp_z;
    } vec_t;

    typedef struct {
        int          id;
        logic [7:0]  side;
        logic [63:0] exp_z;
        int          cyc;
    } pend_t;

    logic              clk = 1'b0;
    logic              s_rst_n;
    logic [N-1:0]      req_vld;
    logic [N-1:0]      req_rdy;
    logic [N*OPW-1:0]  req_a;
    logic [N*UW-1:0]   req_side;
    logic [N-1:0]      credit_rtn;
    logic [N-1:0]      out_avail;
    logic [ZW-1:0]     out_z;
    logic [UW-1:0]     out_side;
    logic              busy;
    logic              error_credit;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          rtn_mode = 0;
    int          owed [N];
    logic [N-1:0] avail_seen = '0;
    pend_t       exp_q [$];
    vec_t        vecs [8];

    ntt_core_gf64_pmr_arb #(
        .N_REQ(N), .MOD_NTT_W(64), .OP_W(OPW), .USER_W(UW), .IN_PIPE(1), .CREDIT_NB(4)
    ) dut (
        .clk(clk), .s_rst_n(s_rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_a(req_a), .req_side(req_side), .credit_rtn(credit_rtn),
        .out_avail(out_avail), .out_z(out_z), .out_side(out_side),
        .busy(busy), .error_credit(error_credit)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reduce a signed value into [0, MOD_M) by true modular division
    function automatic logic [63:0] refReduce(input logic signed [127:0] v);
        logic signed [127:0] m;
        logic signed [127:0] r;
        m = 128'shFFFFFFFF00000001;
        r = v % m;
        if (r < 0) r = r + m;
        return r[63:0];
    endfunction

    function automatic logic [63:0] reduceOp(input logic [66:0] a);
        return refReduce({{61{a[66]}}, a});
    endfunction

    function automatic logic [63:0] reduceZ(input logic [65:0] z);
        return refReduce({{62{z[65]}}, z});
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard the current cycle, then advance and drive credit returns
    task automatic nextCycle();
        pend_t e;
        bit    due;
        #1;
        if (!s_rst_n) begin
            exp_q.delete();
            checkOutput("rst_avail", 128'(out_avail), 128'(0));
            checkOutput("rst_rdy", 128'(req_rdy), 128'(0));
            avail_seen = '0;
        end else begin
            checkOutput("rdy_legal", 128'($onehot0(req_rdy) && ((req_rdy & ~req_vld) == '0)), 128'(1));
            checkOutput("avail_onehot", 128'($onehot0(out_avail)), 128'(1));
            due = (exp_q.size() > 0) && (exp_q[0].cyc + 3 <= cyc);
            if (out_avail != '0 || due) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_avail", 128'(out_avail), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("res_route", 128'(out_avail), 128'(4'b0001 << e.id));
                    checkOutput("res_z", 128'(reduceZ(out_z)), 128'(e.exp_z));
                    checkOutput("res_side", 128'(out_side), 128'(e.side));
                    checkOutput("res_latency", 128'(cyc - e.cyc), 128'(3));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_vld[i] && req_rdy[i]) begin
                    e.id    = i;
                    e.side  = req_side[i*UW +: UW];
                    e.exp_z = reduceOp(req_a[i*OPW +: OPW]);
                    e.cyc   = cyc;
                    exp_q.push_back(e);
                end
            end
            avail_seen = out_avail;
        end
        @(negedge clk);
        cyc++;
        credit_rtn = '0;
        for (int i = 0; i < N; i++) begin
            if (avail_seen[i]) owed[i]++;
            if (owed[i] > 0 && (rtn_mode == 1 || (rtn_mode == 2 && $urandom_range(0, 2) == 0))) begin
                credit_rtn[i] = 1'b1;
                owed[i]--;
            end
        end
    endtask

    task automatic doReset();
        s_rst_n  = 1'b0;
        req_vld  = '1;
        rtn_mode = 0;
        for (int i = 0; i < N; i++) owed[i] = 0;
        credit_rtn = '0;
        nextCycle();
        #1;
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_err", 128'(error_credit), 128'(0));
        nextCycle();
        s_rst_n = 1'b1;
        req_vld = '0;
    endtask

    // One isolated operation from the table with hand-computed result
    task automatic applyStimulus(input vec_t v);
        req_vld = 4'b0001 << v.id;
        req_a[v.id*OPW +: OPW]  = v.a;
        req_side[v.id*UW +: UW] = v.side;
        #1;
        checkOutput("tbl_rdy", 128'(req_rdy), 128'(4'b0001 << v.id));
        nextCycle();
        req_vld = '0;
        #1;
        checkOutput("tbl_busy_on", 128'(busy), 128'(1));
        nextCycle();
        nextCycle();
        #1;
        checkOutput("tbl_avail", 128'(out_avail), 128'(4'b0001 << v.id));
        checkOutput("tbl_z", 128'(reduceZ(out_z)), 128'(v.exp_z));
        checkOutput("tbl_side", 128'(out_side), 128'(v.side));
        nextCycle();
        #1;
        checkOutput("tbl_busy_off", 128'(busy), 128'(0));
    endtask

    initial begin
        int acc;
        int osum;
        logic [31:0] r0, r1, r2;
        logic [66:0] ra;

        vecs[0] = '{0, 67'd5,                         8'h11, 64'd5};
        vecs[1] = '{2, 67'h7_FFFF_FFFF_FFFF_FFFF,     8'h22, 64'hFFFF_FFFF_0000_0000};
        vecs[2] = '{2, 67'h1_0000_0000_0000_0000,     8'h33, 64'h0000_0000_FFFF_FFFF};
        vecs[3] = '{1, 67'h0_FFFF_FFFF_0000_0001,     8'h44, 64'h0};
        vecs[4] = '{3, 67'h3_FFFF_FFFF_FFFF_FFFF,     8'h55, 64'h0000_0003_FFFF_FFFB};
        vecs[5] = '{0, 67'h4_0000_0000_0000_0000,     8'h66, 64'hFFFF_FFFB_0000_0005};
        vecs[6] = '{3, 67'h1_0000_0000_0000_0005,     8'h77, 64'h0000_0001_0000_0004};
        vecs[7] = '{2, 67'h0_0000_0001_0000_0000,     8'h88, 64'h0000_0001_0000_0000};

        s_rst_n = 1'b0; req_vld = '0; req_a = '0; req_side = '0; credit_rtn = '0;
        for (int i = 0; i < N; i++) owed[i] = 0;
        @(negedge clk);
        doReset();

        // Table of isolated operations
        rtn_mode = 1;
        foreach (vecs[v]) applyStimulus(vecs[v]);
        for (int k = 0; k < 4; k++) nextCycle();

        // All requesters saturating, credits echoed: strict 0,1,2,3 rotation
        $display("[TB] round-robin stream");
        doReset();
        rtn_mode = 1;
        for (int k = 0; k < 24; k++) begin
            req_vld = 4'hF;
            for (int i = 0; i < N; i++) begin
                req_a[i*OPW +: OPW] = 67'(k * 16 + i);
                req_side[i*UW +: UW] = 8'(k * 4 + i);
            end
            #1;
            checkOutput("rr_grant", 128'(req_rdy), 128'(4'b0001 << (k % 4)));
            if (k >= 3) checkOutput("rr_avail", 128'(out_avail), 128'(4'b0001 << ((k - 3) % 4)));
            nextCycle();
        end
        req_vld = '0;
        for (int k = 0; k < 6; k++) nextCycle();
        #1;
        checkOutput("rr_err", 128'(error_credit), 128'(0));

        // Credit exhaustion on requester 1
        $display("[TB] credit exhaustion");
        doReset();
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            req_vld = 4'b0010;
            #1;
            if (req_rdy[1]) acc++;
            nextCycle();
        end
        checkOutput("cr_accepts", 128'(acc), 128'(4));
        req_vld = 4'b0010;
        credit_rtn[1] = 1'b1;
        #1;
        checkOutput("cr_pulse_rdy", 128'(req_rdy), 128'(0));
        nextCycle();
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            req_vld = 4'b0010;
            #1;
            if (req_rdy[1]) acc++;
            nextCycle();
        end
        checkOutput("cr_one_more", 128'(acc), 128'(1));
        req_vld = 4'b0010;
        credit_rtn[1] = 1'b1;
        nextCycle();
        req_vld = 4'b0010;
        credit_rtn[1] = 1'b1;
        #1;
        checkOutput("cr_simul_rdy", 128'(req_rdy), 128'(4'b0010));
        nextCycle();
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            req_vld = 4'b0010;
            #1;
            if (req_rdy[1]) acc++;
            nextCycle();
        end
        checkOutput("cr_after_simul", 128'(acc), 128'(1));
        req_vld = '0;
        for (int k = 0; k < 4; k++) nextCycle();

        // Over-return on requester 3
        $display("[TB] credit overflow");
        doReset();
        #1;
        checkOutput("err_before", 128'(error_credit), 128'(0));
        credit_rtn[3] = 1'b1;
        nextCycle();
        #1;
        checkOutput("err_set", 128'(error_credit), 128'(1));
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            req_vld = 4'b1000;
            #1;
            if (req_rdy[3]) acc++;
            nextCycle();
        end
        checkOutput("err_credit_held", 128'(acc), 128'(4));
        req_vld = '0;
        for (int k = 0; k < 4; k++) nextCycle();
        #1;
        checkOutput("err_sticky", 128'(error_credit), 128'(1));
        doReset();
        #1;
        checkOutput("err_cleared", 128'(error_credit), 128'(0));

        // Reset with three operations in flight
        $display("[TB] reset mid-operation");
        for (int k = 0; k < 3; k++) begin
            req_vld = 4'hF;
            #1;
            checkOutput("mid_grant", 128'(req_rdy), 128'(4'b0001 << k));
            nextCycle();
        end
        s_rst_n = 1'b0;
        req_vld = '0;
        nextCycle();
        nextCycle();
        s_rst_n = 1'b1;
        req_vld = 4'hF;
        #1;
        checkOutput("mid_first_rdy", 128'(req_rdy), 128'(4'b0001));
        checkOutput("mid_avail", 128'(out_avail), 128'(0));
        checkOutput("mid_busy", 128'(busy), 128'(0));
        nextCycle();
        acc = 1;
        for (int k = 0; k < 7; k++) begin
            req_vld = 4'b0001;
            #1;
            if (req_rdy[0]) acc++;
            nextCycle();
        end
        checkOutput("mid_credit_restored", 128'(acc), 128'(4));
        req_vld = '0;
        for (int k = 0; k < 6; k++) nextCycle();
        #1;
        checkOutput("mid_idle", 128'(busy), 128'(0));

        // Random stream with random credit-return delay
        $display("[TB] random stream");
        doReset();
        rtn_mode = 2;
        for (int k = 0; k < 3000; k++) begin
            req_vld = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                r0 = $urandom; r1 = $urandom; r2 = $urandom;
                ra = {r0[2:0], r1, r2};
                req_a[i*OPW +: OPW]  = ra;
                req_side[i*UW +: UW] = 8'($urandom);
            end
            nextCycle();
        end
        req_vld = '0;
        for (int k = 0; k < 400; k++) begin
            osum = 0;
            for (int i = 0; i < N; i++) osum += owed[i];
            if (exp_q.size() == 0 && osum == 0) break;
            nextCycle();
        end
        osum = 0;
        for (int i = 0; i < N; i++) osum += owed[i];
        #1;
        checkOutput("rnd_drain_q", 128'(exp_q.size()), 128'(0));
        checkOutput("rnd_owed", 128'(osum), 128'(0));
        checkOutput("rnd_err", 128'(error_credit), 128'(0));
        checkOutput("rnd_busy", 128'(busy), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
